// File: rtl/sdram_aref_burst.sv
// SDRAM auto-refresh engine: interval timer, pending-refresh accounting and a
// burst FSM that issues PRE-all followed by up to MAX_BURST AREF commands per grant.
module sdram_aref_burst #(
    parameter int T_REFI    = 750,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 7,
    parameter int MAX_PEND  = 8,
    parameter int MAX_BURST = 8,
    localparam int PW       = $clog2(MAX_PEND + 1)
) (
    input  logic          ar_clk,
    input  logic          ar_rst_n,
    input  logic          init_end,
    input  logic          ar_en,
    output logic          ar_req,
    output logic          ar_urgent,
    output logic          ar_end,
    output logic [3:0]    ar_cmd,
    output logic [1:0]    ar_bank,
    output logic [12:0]   ar_addr,
    output logic [PW-1:0] ar_pend,
    output logic          ar_ovf
);

    localparam int TW   = (T_REFI > 1) ? $clog2(T_REFI) : 1;
    localparam int DMAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int DW   = $clog2(DMAX);

    localparam logic [TW-1:0] C_TMR_LAST  = TW'(T_REFI - 1);
    localparam logic [PW-1:0] C_PEND_MAX  = PW'(MAX_PEND);
    localparam logic [PW-1:0] C_PEND_URG  = PW'(MAX_PEND - 1);
    localparam logic [PW-1:0] C_BURST_MAX = PW'(MAX_BURST);
    localparam logic [DW-1:0] C_TRP_LAST  = DW'(T_RP - 2);
    localparam logic [DW-1:0] C_TRFC_LAST = DW'(T_RFC - 2);

    localparam logic [3:0] C_CMD_NOP  = 4'b0111;
    localparam logic [3:0] C_CMD_PRE  = 4'b0010;
    localparam logic [3:0] C_CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_TRP  = 3'd2,
        S_AR   = 3'd3,
        S_TRFC = 3'd4,
        S_END  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tmr;
    logic [PW-1:0] r_pend;
    logic [PW-1:0] w_pend_nxt;
    logic [PW-1:0] r_bcnt;
    logic [PW-1:0] w_bload;
    logic [DW-1:0] r_dcnt;
    logic          r_ovf;
    logic          w_ovf_nxt;
    logic          w_tick;
    logic          w_aref;
    logic [3:0]    r_cmd;
    logic          r_req;
    logic          r_urgent;
    logic          r_end;

    // Command encoding for the state the FSM is about to occupy.
    function automatic logic [3:0] cmd_of(input state_t s);
        logic [3:0] c;
        case (s)
            S_PRE:   c = C_CMD_PRE;
            S_AR:    c = C_CMD_AREF;
            default: c = C_CMD_NOP;
        endcase
        return c;
    endfunction

    assign w_tick  = init_end && (r_tmr == C_TMR_LAST);
    assign w_aref  = (r_state == S_AR);
    assign w_bload = (r_pend > C_BURST_MAX) ? C_BURST_MAX : r_pend;

    assign ar_req    = r_req;
    assign ar_urgent = r_urgent;
    assign ar_end    = r_end;
    assign ar_cmd    = r_cmd;
    assign ar_bank   = 2'b11;
    assign ar_addr   = 13'h1FFF;
    assign ar_pend   = r_pend;
    assign ar_ovf    = r_ovf;

    // Refresh interval timer: parked at zero until init completes, then free-running.
    always_ff @(posedge ar_clk or negedge ar_rst_n) begin
        if (!ar_rst_n) begin
            r_tmr <= {TW{1'b0}};
        end else if (!init_end || w_tick) begin
            r_tmr <= {TW{1'b0}};
        end else begin
            r_tmr <= r_tmr + TW'(1);
        end
    end

    // Next pending count: a tick and an AREF in the same cycle cancel out.
    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_nxt  = r_ovf;
        case ({w_tick, w_aref})
            2'b10: begin
                if (r_pend == C_PEND_MAX) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_pend_nxt = r_pend + PW'(1);
                end
            end
            2'b01:   w_pend_nxt = r_pend - PW'(1);
            default: w_pend_nxt = r_pend;
        endcase
    end

    // Pending-refresh counter and sticky overflow flag.
    always_ff @(posedge ar_clk or negedge ar_rst_n) begin
        if (!ar_rst_n) begin
            r_pend <= {PW{1'b0}};
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    // Burst FSM next-state logic; ar_en only matters in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (ar_en && r_req && init_end) begin
                    w_state_nxt = S_PRE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PRE:  w_state_nxt = S_TRP;
            S_TRP: begin
                if (r_dcnt == C_TRP_LAST) begin
                    w_state_nxt = S_AR;
                end else begin
                    w_state_nxt = S_TRP;
                end
            end
            S_AR:   w_state_nxt = S_TRFC;
            S_TRFC: begin
                if (r_dcnt != C_TRFC_LAST) begin
                    w_state_nxt = S_TRFC;
                end else if (r_bcnt != {PW{1'b0}}) begin
                    w_state_nxt = S_AR;
                end else begin
                    w_state_nxt = S_END;
                end
            end
            S_END:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge ar_clk or negedge ar_rst_n) begin
        if (!ar_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst length: snapshot of the backlog at grant, one off per AREF; later ticks don't extend it.
    always_ff @(posedge ar_clk or negedge ar_rst_n) begin
        if (!ar_rst_n) begin
            r_bcnt <= {PW{1'b0}};
        end else if ((r_state == S_IDLE) && (w_state_nxt == S_PRE)) begin
            r_bcnt <= w_bload;
        end else if (w_aref) begin
            r_bcnt <= r_bcnt - PW'(1);
        end else begin
            r_bcnt <= r_bcnt;
        end
    end

    // Shared TRP/TRFC duration counter, restarted on every state change.
    always_ff @(posedge ar_clk or negedge ar_rst_n) begin
        if (!ar_rst_n) begin
            r_dcnt <= {DW{1'b0}};
        end else if (w_state_nxt != r_state) begin
            r_dcnt <= {DW{1'b0}};
        end else if ((r_state == S_TRP) || (r_state == S_TRFC)) begin
            r_dcnt <= r_dcnt + DW'(1);
        end else begin
            r_dcnt <= {DW{1'b0}};
        end
    end

    // Registered outputs computed from next state/count so they line up with r_state/r_pend.
    always_ff @(posedge ar_clk or negedge ar_rst_n) begin
        if (!ar_rst_n) begin
            r_cmd    <= C_CMD_NOP;
            r_req    <= 1'b0;
            r_urgent <= 1'b0;
            r_end    <= 1'b0;
        end else begin
            r_cmd    <= cmd_of(w_state_nxt);
            r_req    <= (w_state_nxt == S_IDLE) && (w_pend_nxt != {PW{1'b0}});
            r_urgent <= (w_pend_nxt >= C_PEND_URG);
            r_end    <= (w_state_nxt == S_END);
        end
    end

endmodule

// File: doc/sdram_aref_burst.md
SDRAM_AREF_BURST -- requirements
Module: sdram_aref_burst

Interface
REQ-001 Parameter T_REFI, default 750, average refresh interval in ar_clk cycles (7.5 us at 100 MHz).
REQ-002 Parameter T_RP, default 2, precharge-to-refresh spacing in cycles; legal range 2 or more.
REQ-003 Parameter T_RFC, default 7, refresh-to-next-command spacing in cycles; legal range 2 or more.
REQ-004 Parameter MAX_PEND, default 8, saturation limit of the pending-refresh counter; legal range 2 or more.
REQ-005 Parameter MAX_BURST, default 8, maximum number of AREF commands issued per grant; legal range 1 to MAX_PEND.
REQ-006 Port ar_clk  in  1  sole clock; all logic is on the rising edge.
REQ-007 Port ar_rst_n  in  1  asynchronous, active-low reset.
REQ-008 Port init_end  in  1  SDRAM initialisation complete; held high once set.
REQ-009 Port ar_en  in  1  arbiter grant; level signal, held high until ar_end.
REQ-010 Port ar_req  out  1  refresh wanted; high whenever pend is at least 1 and the FSM is in IDLE.
REQ-011 Port ar_urgent  out  1  high whenever pend is at least MAX_PEND-1.
REQ-012 Port ar_end  out  1  one-cycle pulse marking burst completion.
REQ-013 Port ar_cmd  out  4  {cs_n,ras_n,cas_n,we_n}: NOP=0111, PRE=0010, AREF=0001.
REQ-014 Port ar_bank  out  2  always 2'b11.
REQ-015 Port ar_addr  out  13  always 13'h1FFF, so A10=1 selects precharge-all.
REQ-016 Port ar_pend  out  clog2(MAX_PEND+1)  current pending-refresh count.
REQ-017 Port ar_ovf  out  1  sticky flag: an interval tick arrived while pend was at MAX_PEND.

Function
REQ-018 Interval timer:
- Held at 0 while init_end=0.
- Otherwise counts 0 to T_REFI-1 and wraps.
- Wrap cycle produces one tick.
REQ-019 pend update per cycle:
- Tick only: +1.
- AREF issued only: -1.
- Tick and AREF in the same cycle: unchanged.
- Tick while pend=MAX_PEND: pend stays at MAX_PEND and ar_ovf sets.
REQ-020 FSM states: IDLE, PRE, TRP, AR, TRFC, END.
REQ-021 Command output per state:
- ar_cmd=NOP in IDLE, TRP, TRFC and END.
- ar_cmd=PRE for exactly one cycle in PRE.
- ar_cmd=AREF for exactly one cycle in each AR visit.
REQ-022 IDLE->PRE when ar_en=1, ar_req=1 and init_end=1; ar_en is ignored in every other state.
REQ-023 On the IDLE->PRE edge, burst count bcnt is loaded with min(pend, MAX_BURST).
REQ-024 PRE->TRP unconditionally; TRP lasts T_RP-1 cycles, then ->AR, so PRE-to-AREF spacing is exactly T_RP cycles.
REQ-025 AR->TRFC and bcnt decrements; TRFC lasts T_RFC-1 cycles, so consecutive AREFs are exactly T_RFC cycles apart.
REQ-026 TRFC exit: ->AR if bcnt is non-zero, else ->END.
REQ-027 END lasts one cycle with ar_end=1, then ->IDLE; ar_req is low in every state except IDLE.
REQ-028 Ticks arriving mid-burst only raise pend; they never extend the current burst.
REQ-029 A single state-duration counter serves TRP and TRFC; it clears on every state change.

Reset
REQ-030 On ar_rst_n=0, asynchronously:
- State forced to IDLE.
- Timer, pend, bcnt and ar_ovf cleared.
- ar_cmd=NOP, ar_req=0, ar_urgent=0, ar_end=0.
- ar_bank and ar_addr at their constant values.
REQ-031 Reset mid-burst aborts the burst with no further PRE or AREF; operation resumes from REQ-018 after release.
REQ-032 init_end falling is not supported; behaviour is defined only for init_end constant high after rising.

Verification (T_REFI=20, T_RP=2, T_RFC=7, MAX_PEND=4, MAX_BURST=4 unless stated)
REQ-033 Hold init_end=0 for 100 cycles -> ar_pend=0, ar_req=0, ar_cmd=0111 throughout.
REQ-034 init_end=1, ar_en tied to ar_req -> first tick 20 cycles after init_end rises; then PRE, AREF 2 cycles later, ar_end 7 cycles after AREF; ar_pend returns to 0.
REQ-035 init_end=1, ar_en=0 for 70 cycles -> ar_pend=3, ar_urgent=1.
  Then grant -> PRE, then 3 AREFs spaced 7 cycles apart, one ar_end, ar_pend=0.
REQ-036 ar_en=0 for 110 cycles -> ar_pend saturates at 4 and ar_ovf=1.
  Then grant -> 4 AREFs; ar_ovf stays 1 until reset.
REQ-037 Rerun REQ-035 with MAX_BURST=2 and pend=3 -> exactly 2 AREFs, ar_end, ar_pend=1, ar_req reasserts in IDLE.
REQ-038 Assert ar_rst_n=0 in the cycle after the second AREF -> next edge shows ar_cmd=0111, FSM in IDLE, ar_pend=0, and no AREF while reset is held.
